// File: rtl/mem_responder.sv
// mem_responder: single-outstanding, fixed-latency memory target.
// Accepts one load/store at a time, performs the array access at the
// acceptance edge, then presents the response after LATENCY edges and
// holds it until the initiator takes it.
//
// Handshake rules (both channels): a transfer happens at a rising edge
// where valid and ready are both high. The request side is ready only in
// IDLE. The response side keeps valid and all payload fields stable until
// rsp_ready_i is seen high. No output depends combinationally on an input.
module mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 5
) (
  input  logic        clk_i,
  input  logic        rsn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_error_o,
  output logic [1:0]  dbg_state_o
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic [31:0] mem [DEPTH];
  logic [31:0] rsp_data;
  logic        rsp_error;

  logic          accept;
  logic          addr_err;
  logic [AW-1:0] word_idx;

  // rsn_i gates acceptance so nothing reaches the array while in reset.
  assign accept   = req_valid_i && (state == S_IDLE) && rsn_i;
  assign addr_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i >= ADDR_LIMIT);
  assign word_idx = req_addr_i[AW+1:2];

  assign req_ready_o = (state == S_IDLE);
  assign rsp_valid_o = (state == S_RESP);
  assign rsp_data_o  = rsp_data;
  assign rsp_error_o = rsp_error;
  assign dbg_state_o = state;

  // State and latency counter registers.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_n = S_RESP;
          end else begin
            state_n = S_WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_n = S_RESP;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // Byte-masked store into the array; contents survive reset by design.
  always_ff @(posedge clk_i) begin
    if (accept && req_write_i && !addr_err) begin
      for (int k = 0; k < 4; k++) begin
        if (req_be_i[k]) mem[word_idx][8*k +: 8] <= req_wdata_i[8*k +: 8];
      end
    end
  end

  // Response payload: captured at acceptance, cleared when the response is taken.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      rsp_data  <= 32'd0;
      rsp_error <= 1'b0;
    end else if (accept) begin
      rsp_error <= addr_err;
      rsp_data  <= (addr_err || req_write_i) ? 32'd0 : mem[word_idx];
    end else if ((state == S_RESP) && rsp_ready_i) begin
      rsp_data  <= 32'd0;
      rsp_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand-written corner
// sequences (backpressure, LATENCY=1 throughput, reset mid-request) and a
// randomized phase checked against a word-array reference model.
module tb_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rsn;

  // main instance (LATENCY = 5)
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_data;
  logic [1:0]  dbg_state;

  // second instance (LATENCY = 1), response always taken
  logic        b_valid, b_ready, b_write;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_be;
  logic        b_rsp_valid, b_rsp_error;
  logic [31:0] b_rsp_data;
  logic [1:0]  b_state;
  wire         b_rsp_ready = 1'b1;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk), .rsn_i(rsn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_be_i(req_be), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_error_o(rsp_error), .dbg_state_o(dbg_state)
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk_i(clk), .rsn_i(rsn),
    .req_valid_i(b_valid), .req_ready_o(b_ready), .req_write_i(b_write),
    .req_addr_i(b_addr), .req_be_i(b_be), .req_wdata_i(b_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_data_o(b_rsp_data), .rsp_error_o(b_rsp_error), .dbg_state_o(b_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: expected event did not occur (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mdl [int unsigned];

  function automatic logic mdl_err(input logic [31:0] a);
    return ((a % 4) != 0) || (longint'(a) >= longint'(DEPTH) * 4);
  endfunction

  function automatic void mdl_store(input logic [31:0] a, input logic [3:0] be,
                                    input logic [31:0] wd);
    logic [31:0] w;
    if (mdl_err(a)) return;
    w = mdl.exists(a / 4) ? mdl[a / 4] : 32'hxxxx_xxxx;
    for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = wd[8*k +: 8];
    mdl[a / 4] = w;
  endfunction

  function automatic logic [31:0] mdl_rsp(input logic w, input logic [31:0] a);
    if (mdl_err(a) || w) return 32'd0;
    return mdl[a / 4];
  endfunction

  // ---------------- driver ----------------
  // Called #1 after a rising edge with the DUT idle. Returns response fields
  // and the number of edges after acceptance before rsp_valid was seen.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input int hold, input bit noise,
                        output logic [31:0] d, output logic e, output int lat);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_be = be; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1)); req_addr = $urandom;
    req_be = 4'($urandom_range(0, 15)); req_wdata = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      if (noise) rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    rsp_ready = 1'b0;
    d = rsp_data; e = rsp_error;
    if (!rsp_valid) begin
      fail_now("rsp_timeout");
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, d);
      chk("hold_err", rsp_error, e);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("valid_clear", rsp_valid, 0);
    chk("ready_back", req_ready, 1);
    chk("data_clear", rsp_data, 0);
    chk("err_clear", rsp_error, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    int          acc[$];
    bit          seen;

    rsn = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_be = 0; req_wdata = 0; rsp_ready = 0;
    b_valid = 0; b_write = 0; b_addr = 0; b_be = 0; b_wdata = 0;

    vecs.push_back('{1'b1, 32'h40,   4'hF, 32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h40,   4'h0, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h80,   4'hF, 32'h11223344, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h80,   4'h5, 32'hAABBCCDD, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h80,   4'h0, 32'h0,        32'h11BB33DD, 1'b0});
    vecs.push_back('{1'b0, 32'h42,   4'h0, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h1000, 4'h0, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h0,    4'hF, 32'h12345678, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h1000, 4'hF, 32'h55,       32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h0,    4'h0, 32'h0,        32'h12345678, 1'b0});
    vecs.push_back('{1'b1, 32'h0,    4'h0, 32'hFFFFFFFF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h0,    4'h0, 32'h0,        32'h12345678, 1'b0});
    vecs.push_back('{1'b0, 32'hFFC,  4'h0, 32'h0,        32'hxxxxxxxx, 1'b0});
    vecs.push_back('{1'b1, 32'h3,    4'hF, 32'h1,        32'h0,        1'b1});

    // reset values, checked while reset is held
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_req_ready", req_ready, 1);
    req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_accept", req_ready, 1);
    req_valid = 1'b0;
    rsn = 1'b1;
    @(posedge clk); #1;

    // directed table
    foreach (vecs[i]) begin
      do_req(vecs[i].write, vecs[i].addr, vecs[i].be, vecs[i].wdata, 0, 1'b0, d, e, lat);
      chk($sformatf("vec%0d_latency", i), lat, LAT - 1);
      chk($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      if (vecs[i].exp_data !== 32'hxxxxxxxx) chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      if (vecs[i].write) mdl_store(vecs[i].addr, vecs[i].be, vecs[i].wdata);
    end

    // backpressure: hold response for 7 cycles
    do_req(1'b0, 32'h40, 4'h0, 32'h0, 7, 1'b0, d, e, lat);
    chk("bp_data", d, 32'hDEADBEEF);
    chk("bp_err", e, 0);

    // LATENCY=1 back-to-back with response always taken
    b_valid = 1'b1; b_write = 1'b1; b_addr = 32'h0; b_be = 4'h0; b_wdata = 32'h0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bit rdy;
      rdy = b_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc.push_back(cyc);
        chk("b2b_rsp_valid", b_rsp_valid, 1);
      end
    end
    b_valid = 1'b0;
    chk("b2b_count", acc.size(), 10);
    for (int i = 1; i < acc.size(); i++) chk("b2b_spacing", acc[i] - acc[i-1], 2);
    @(posedge clk); #1;

    // reset mid-WAIT: load is discarded
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h80; req_be = 4'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rsn = 1'b0;
    #1;
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_data", rsp_data, 0);
    @(posedge clk); @(posedge clk); #1;
    rsn = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("midrst_no_rsp", seen, 0);
    chk("midrst_ready_after", req_ready, 1);
    do_req(1'b0, 32'h80, 4'h0, 32'h0, 0, 1'b0, d, e, lat);
    chk("midrst_reload", d, 32'h11BB33DD);

    // reset mid-WAIT after a store: the store stays committed
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h100; req_be = 4'hF; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mdl_store(32'h100, 4'hF, 32'hCAFEF00D);
    @(posedge clk); @(posedge clk); #1;
    rsn = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rsn = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 32'h100, 4'h0, 32'h0, 0, 1'b0, d, e, lat);
    chk("store_commit", d, 32'hCAFEF00D);

    // randomized phase: prefill a 16-word region, then mixed traffic
    for (int i = 0; i < 16; i++) begin
      logic [31:0] wd;
      wd = $urandom;
      do_req(1'b1, 32'h200 + 32'(i * 4), 4'hF, wd, 0, 1'b0, d, e, lat);
      mdl_store(32'h200 + 32'(i * 4), 4'hF, wd);
    end
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, wd;
      logic        w;
      logic [3:0]  be;
      int          kind;
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = 32'h200 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(1, 3));
      else if (kind == 1) a = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFC : 32'h1000 + 32'($urandom_range(0, 1000) * 4);
      else                a = 32'h200 + 32'($urandom_range(0, 15) * 4);
      w  = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      exp_q.push_back(mdl_rsp(w, a));
      do_req(w, a, be, wd, $urandom_range(0, 3), 1'b1, d, e, lat);
      chk("rnd_latency", lat, LAT - 1);
      chk("rnd_err", e, mdl_err(a));
      chk("rnd_data", d, exp_q.pop_front());
      if (w) mdl_store(a, be, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
